// File: rtl/mac_accum_stream.sv
// Streaming multiply-accumulate: one dot product per in_last-delimited vector,
// with optional saturation, a sticky overflow flag and a per-vector beat count.
module mac_accum_stream #(
    parameter int A_W    = 8,
    parameter int B_W    = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 0,
    parameter int SAT_EN = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    localparam int P_W   = A_W + B_W;
    localparam int EXT_W = ACC_W + 1 - P_W;

    logic [P_W-1:0]   prod_p0;
    logic [P_W-1:0]   prod_p1;
    logic             vld_p1;
    logic             last_p1;
    logic [ACC_W-1:0] acc_p2;
    logic [CNT_W-1:0] cnt_p2;
    logic             ovf_p2;

    logic             stall;
    logic             accept;
    logic             advance;
    logic [ACC_W:0]   sum_p1;
    logic             sum_ovf;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;

    // Operands are extended to the full product width, so the low P_W bits of
    // a plain multiply are correct for both two's complement and unsigned.
    function automatic logic [P_W-1:0] mul_ext(input logic [A_W-1:0] a,
                                               input logic [B_W-1:0] b);
        logic [P_W-1:0] ea;
        logic [P_W-1:0] eb;
        ea = {{B_W{(SIGNED != 0) & a[A_W-1]}}, a};
        eb = {{A_W{(SIGNED != 0) & b[B_W-1]}}, b};
        return ea * eb;
    endfunction

    function automatic logic add_ovf(input logic [ACC_W:0] s);
        if (SIGNED != 0)
            return s[ACC_W] ^ s[ACC_W-1];
        return s[ACC_W];
    endfunction

    // Bit ACC_W of the extended sum gives the true sign, i.e. the clamp direction.
    function automatic logic [ACC_W-1:0] sat_wrap(input logic [ACC_W:0] s);
        logic [ACC_W-1:0] r;
        r = s[ACC_W-1:0];
        if ((SAT_EN != 0) && add_ovf(s)) begin
            if (SIGNED == 0)
                r = '1;
            else if (s[ACC_W])
                r = {1'b1, {(ACC_W-1){1'b0}}};
            else
                r = {1'b0, {(ACC_W-1){1'b1}}};
        end
        return r;
    endfunction

    // A completed vector can only retire into the result register once the
    // previous result has been taken; everything upstream freezes meanwhile.
    assign stall    = out_valid & ~out_ready & vld_p1 & last_p1;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;
    assign advance  = vld_p1 & ~stall;

    assign prod_p0  = mul_ext(in_a, in_b);
    assign sum_p1   = {(SIGNED != 0) & acc_p2[ACC_W-1], acc_p2}
                    + {{EXT_W{(SIGNED != 0) & prod_p1[P_W-1]}}, prod_p1};
    assign sum_ovf  = add_ovf(sum_p1);
    assign acc_next = sat_wrap(sum_p1);
    assign ovf_next = ovf_p2 | sum_ovf;
    assign cnt_next = cnt_p2 + CNT_W'(1);

    // ---- stage 1: register the product of an accepted beat ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            prod_p1 <= '0;
        end else if (!stall) begin
            vld_p1 <= accept;
            if (accept) begin
                prod_p1 <= prod_p0;
                last_p1 <= in_last;
            end
        end
    end

    // ---- stage 2: accumulate, restarting after the last beat of a vector ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p2 <= '0;
            cnt_p2 <= '0;
            ovf_p2 <= 1'b0;
        end else if (advance) begin
            if (last_p1) begin
                acc_p2 <= '0;
                cnt_p2 <= '0;
                ovf_p2 <= 1'b0;
            end else begin
                acc_p2 <= acc_next;
                cnt_p2 <= cnt_next;
                ovf_p2 <= ovf_next;
            end
        end
    end

    // ---- result register: a new result may replace one taken on the same edge ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else if (advance && last_p1) begin
            out_valid <= 1'b1;
            out_data  <= acc_next;
            out_ovf   <= ovf_next;
            out_count <= cnt_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_accum_stream.sv
// Bench for mac_accum_stream: directed scenarios plus randomized traffic against
// an arithmetic dot-product model, over unsigned/24-bit and signed/16-bit configs.
module tb_mac_accum_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;

    logic        u_ready, u_valid, u_ovf;
    logic [23:0] u_data;
    logic [7:0]  u_cnt;
    logic        s_ready, s_valid, s_ovf;
    logic [15:0] s_data;
    logic [7:0]  s_cnt;
    logic        w_ready, w_valid, w_ovf;
    logic [15:0] w_data;
    logic [7:0]  w_cnt;

    int n_checks = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [23:0] data;
        logic        ovf;
        logic [7:0]  cnt;
    } exp_t;

    int   va[$];
    int   vb[$];
    exp_t q_u[$];
    exp_t q_s[$];
    exp_t q_w[$];

    always #5 clk = ~clk;

    mac_accum_stream u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(u_valid),
        .out_ready(out_ready), .out_data(u_data), .out_ovf(u_ovf), .out_count(u_cnt)
    );

    mac_accum_stream #(.SIGNED(1), .ACC_W(16), .SAT_EN(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(s_valid),
        .out_ready(out_ready), .out_data(s_data), .out_ovf(s_ovf), .out_count(s_cnt)
    );

    mac_accum_stream #(.SIGNED(1), .ACC_W(16), .SAT_EN(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(w_valid),
        .out_ready(out_ready), .out_data(w_data), .out_ovf(w_ovf), .out_count(w_cnt)
    );

    // cfg 0: unsigned 24-bit saturating; 1: signed 16-bit saturating; 2: signed 16-bit wrapping
    function automatic exp_t model_vec(input int cfg);
        longint acc = 0;
        logic   ovf = 1'b0;
        exp_t   e;
        for (int i = 0; i < va.size(); i++) begin
            longint a = va[i];
            longint b = vb[i];
            if (cfg != 0) begin
                if (a >= 128) a = a - 256;
                if (b >= 128) b = b - 256;
            end
            acc = acc + a * b;
            if (cfg == 0) begin
                if (acc > 16777215) begin ovf = 1'b1; acc = 16777215; end
            end else if (cfg == 1) begin
                if (acc > 32767) begin ovf = 1'b1; acc = 32767; end
                else if (acc < -32768) begin ovf = 1'b1; acc = -32768; end
            end else begin
                if (acc > 32767) begin ovf = 1'b1; acc = acc - 65536; end
                else if (acc < -32768) begin ovf = 1'b1; acc = acc + 65536; end
            end
        end
        e.data = 24'(acc);
        e.ovf  = ovf;
        e.cnt  = 8'(va.size());
        return e;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_a = 8'd0; in_b = 8'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic put(input logic [7:0] a, input logic [7:0] b, input logic l);
        in_valid = 1'b1; in_a = a; in_b = b; in_last = l;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (u_valid !== 1'b0) $display("FAIL rst_valid actual=%0d expected=0", u_valid); else n_pass++;
        n_checks++; if (u_data !== 24'd0) $display("FAIL rst_data actual=%0h expected=0", u_data); else n_pass++;
        n_checks++; if (u_cnt !== 8'd0 || u_ovf !== 1'b0) $display("FAIL rst_cnt_ovf actual=%0d/%0d expected=0/0", u_cnt, u_ovf); else n_pass++;
        n_checks++; if (u_ready !== 1'b1) $display("FAIL rst_ready actual=%0d expected=1", u_ready); else n_pass++;
        // reset in the middle of a vector discards the partial sum and the in-flight product
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        put(8'd9, 8'd9, 1'b0);
        put(8'd9, 8'd9, 1'b0);
        rst_n = 1'b0; #2;
        n_checks++; if (u_valid !== 1'b0 || u_data !== 24'd0 || u_cnt !== 8'd0) $display("FAIL rst_mid actual=%0d/%0h/%0d expected=0/0/0", u_valid, u_data, u_cnt); else n_pass++;
        n_checks++; if (u_ready !== 1'b1) $display("FAIL rst_mid_ready actual=%0d expected=1", u_ready); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        put(8'd1, 8'd1, 1'b1);
        idle(1);
        n_checks++; if (u_valid !== 1'b1 || u_data !== 24'd1 || u_cnt !== 8'd1 || u_ovf !== 1'b0) $display("FAIL rst_after actual=%0d/%0h/%0d/%0d expected=1/1/1/0", u_valid, u_data, u_cnt, u_ovf); else n_pass++;
        // reset while a result is pending and the pipeline is stalled
        do_reset();
        put(8'd1, 8'd1, 1'b1);
        put(8'd2, 8'd2, 1'b1);
        n_checks++; if (u_ready !== 1'b0) $display("FAIL rst_stall_ready actual=%0d expected=0", u_ready); else n_pass++;
        rst_n = 1'b0; #2;
        n_checks++; if (u_valid !== 1'b0 || u_data !== 24'd0 || u_ready !== 1'b1) $display("FAIL rst_stall_clear actual=%0d/%0h/%0d expected=0/0/1", u_valid, u_data, u_ready); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        put(8'd1, 8'd1, 1'b1);
        idle(1);
        n_checks++; if (u_valid !== 1'b1 || u_data !== 24'd1 || u_cnt !== 8'd1) $display("FAIL rst_stall_after actual=%0d/%0h/%0d expected=1/1/1", u_valid, u_data, u_cnt); else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        put(8'd3, 8'd4, 1'b0);
        put(8'd5, 8'd6, 1'b0);
        put(8'd7, 8'd8, 1'b1);
        n_checks++; if (u_valid !== 1'b0) $display("FAIL basic_early actual=%0d expected=0", u_valid); else n_pass++;
        idle(1);
        n_checks++; if (u_valid !== 1'b1) $display("FAIL basic_valid actual=%0d expected=1", u_valid); else n_pass++;
        n_checks++; if (u_data !== 24'd98) $display("FAIL basic_data actual=%0d expected=98", u_data); else n_pass++;
        n_checks++; if (u_cnt !== 8'd3 || u_ovf !== 1'b0) $display("FAIL basic_cnt_ovf actual=%0d/%0d expected=3/0", u_cnt, u_ovf); else n_pass++;
        idle(1);
        n_checks++; if (u_valid !== 1'b0) $display("FAIL basic_taken actual=%0d expected=0", u_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        put(8'd2, 8'd2, 1'b1);
        put(8'd10, 8'd10, 1'b0);
        n_checks++; if (u_valid !== 1'b1 || u_data !== 24'd4 || u_cnt !== 8'd1) $display("FAIL b2b_first actual=%0d/%0d/%0d expected=1/4/1", u_valid, u_data, u_cnt); else n_pass++;
        put(8'd1, 8'd1, 1'b1);
        n_checks++; if (u_valid !== 1'b0) $display("FAIL b2b_gap actual=%0d expected=0", u_valid); else n_pass++;
        idle(1);
        n_checks++; if (u_valid !== 1'b1 || u_data !== 24'd101 || u_cnt !== 8'd2 || u_ovf !== 1'b0) $display("FAIL b2b_second actual=%0d/%0d/%0d/%0d expected=1/101/2/0", u_valid, u_data, u_cnt, u_ovf); else n_pass++;
    endtask

    task automatic test_signed_overflow();
        do_reset();
        out_ready = 1'b1;
        put(8'd127, 8'd127, 1'b0);
        put(8'd127, 8'd127, 1'b0);
        put(8'd127, 8'd127, 1'b1);
        idle(1);
        n_checks++; if (s_data !== 16'h7FFF || s_ovf !== 1'b1 || s_cnt !== 8'd3) $display("FAIL sat_pos actual=%0h/%0d/%0d expected=7fff/1/3", s_data, s_ovf, s_cnt); else n_pass++;
        n_checks++; if (w_data !== 16'hBD03 || w_ovf !== 1'b1) $display("FAIL wrap_pos actual=%0h/%0d expected=bd03/1", w_data, w_ovf); else n_pass++;
        n_checks++; if (u_data !== 24'd48387 || u_ovf !== 1'b0) $display("FAIL unsigned_pos actual=%0d/%0d expected=48387/0", u_data, u_ovf); else n_pass++;
        put(8'h80, 8'd127, 1'b0);
        put(8'h80, 8'd127, 1'b0);
        put(8'h80, 8'd127, 1'b1);
        idle(1);
        n_checks++; if (s_data !== 16'h8000 || s_ovf !== 1'b1 || s_cnt !== 8'd3) $display("FAIL sat_neg actual=%0h/%0d/%0d expected=8000/1/3", s_data, s_ovf, s_cnt); else n_pass++;
        n_checks++; if (w_data !== 16'h4180 || w_ovf !== 1'b1) $display("FAIL wrap_neg actual=%0h/%0d expected=4180/1", w_data, w_ovf); else n_pass++;
        n_checks++; if (u_data !== 24'd48768 || u_ovf !== 1'b0) $display("FAIL unsigned_neg actual=%0d/%0d expected=48768/0", u_data, u_ovf); else n_pass++;
    endtask

    task automatic test_unsigned_sat_count();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) put(8'd255, 8'd255, (i == 259));
        idle(1);
        n_checks++; if (u_data !== 24'hFFFFFF || u_ovf !== 1'b1) $display("FAIL usat_data actual=%0h/%0d expected=ffffff/1", u_data, u_ovf); else n_pass++;
        n_checks++; if (u_cnt !== 8'd4) $display("FAIL cnt_wrap actual=%0d expected=4", u_cnt); else n_pass++;
        n_checks++; if (s_data !== 16'd260 || s_ovf !== 1'b0 || s_cnt !== 8'd4) $display("FAIL signed_neg1 actual=%0d/%0d/%0d expected=260/0/4", s_data, s_ovf, s_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        put(8'd2, 8'd3, 1'b1);
        put(8'd4, 8'd5, 1'b0);
        n_checks++; if (u_valid !== 1'b1 || u_data !== 24'd6 || u_cnt !== 8'd1) $display("FAIL bp_first actual=%0d/%0d/%0d expected=1/6/1", u_valid, u_data, u_cnt); else n_pass++;
        put(8'd6, 8'd7, 1'b1);
        n_checks++; if (u_ready !== 1'b0) $display("FAIL bp_ready_drop actual=%0d expected=0", u_ready); else n_pass++;
        in_valid = 1'b1; in_a = 8'd8; in_b = 8'd9; in_last = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            n_checks++; if (u_ready !== 1'b0 || u_valid !== 1'b1 || u_data !== 24'd6 || u_cnt !== 8'd1 || u_ovf !== 1'b0) $display("FAIL bp_hold actual=%0d/%0d/%0d/%0d expected=0/1/6/1", u_ready, u_valid, u_data, u_cnt); else n_pass++;
        end
        out_ready = 1'b1; #1;
        n_checks++; if (u_ready !== 1'b1) $display("FAIL bp_ready_rise actual=%0d expected=1", u_ready); else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (u_valid !== 1'b1 || u_data !== 24'd62 || u_cnt !== 8'd2) $display("FAIL bp_second actual=%0d/%0d/%0d expected=1/62/2", u_valid, u_data, u_cnt); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (u_valid !== 1'b1 || u_data !== 24'd72 || u_cnt !== 8'd1) $display("FAIL bp_third actual=%0d/%0d/%0d expected=1/72/1", u_valid, u_data, u_cnt); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (u_valid !== 1'b0) $display("FAIL bp_drain actual=%0d expected=0", u_valid); else n_pass++;
    endtask

    task automatic test_random(input int ncyc);
        exp_t e;
        do_reset();
        va.delete(); vb.delete(); q_u.delete(); q_s.delete(); q_w.delete();
        for (int c = 0; c < ncyc + 6; c++) begin
            if (c < ncyc) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                in_a      = 8'($urandom_range(0, 255));
                in_b      = 8'($urandom_range(0, 255));
                in_last   = ($urandom_range(0, 4) == 0);
                out_ready = ($urandom_range(0, 9) < 6);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            n_checks++; if (s_ready !== u_ready || w_ready !== u_ready) $display("FAIL rnd_ready_agree actual=%0d/%0d/%0d expected=equal", u_ready, s_ready, w_ready); else n_pass++;
            if (in_valid && u_ready) begin
                va.push_back(int'(in_a));
                vb.push_back(int'(in_b));
                if (in_last) begin
                    q_u.push_back(model_vec(0));
                    q_s.push_back(model_vec(1));
                    q_w.push_back(model_vec(2));
                    va.delete(); vb.delete();
                end
            end
            if (u_valid && out_ready) begin
                n_checks++;
                if (q_u.size() == 0) $display("FAIL rnd_u_unexpected actual=%0h expected=none", u_data);
                else begin
                    e = q_u.pop_front();
                    if (u_data !== e.data || u_ovf !== e.ovf || u_cnt !== e.cnt) $display("FAIL rnd_u actual=%0h/%0d/%0d expected=%0h/%0d/%0d", u_data, u_ovf, u_cnt, e.data, e.ovf, e.cnt);
                    else n_pass++;
                end
            end
            if (s_valid && out_ready) begin
                n_checks++;
                if (q_s.size() == 0) $display("FAIL rnd_s_unexpected actual=%0h expected=none", s_data);
                else begin
                    e = q_s.pop_front();
                    if (s_data !== e.data[15:0] || s_ovf !== e.ovf || s_cnt !== e.cnt) $display("FAIL rnd_s actual=%0h/%0d/%0d expected=%0h/%0d/%0d", s_data, s_ovf, s_cnt, e.data[15:0], e.ovf, e.cnt);
                    else n_pass++;
                end
            end
            if (w_valid && out_ready) begin
                n_checks++;
                if (q_w.size() == 0) $display("FAIL rnd_w_unexpected actual=%0h expected=none", w_data);
                else begin
                    e = q_w.pop_front();
                    if (w_data !== e.data[15:0] || w_ovf !== e.ovf || w_cnt !== e.cnt) $display("FAIL rnd_w actual=%0h/%0d/%0d expected=%0h/%0d/%0d", w_data, w_ovf, w_cnt, e.data[15:0], e.ovf, e.cnt);
                    else n_pass++;
                end
            end
            @(posedge clk); #1;
        end
        n_checks++; if (q_u.size() != 0 || q_s.size() != 0 || q_w.size() != 0) $display("FAIL rnd_leftover actual=%0d/%0d/%0d expected=0/0/0", q_u.size(), q_s.size(), q_w.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_signed_overflow();
        test_unsigned_sat_count();
        test_backpressure();
        test_random(3000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
